// File: rtl/clefia_round_ctrl.sv
// clefia_round_ctrl: round sequencer for the CLEFIA F0/F1 datapath and its PD in/out pipeline
module clefia_round_ctrl #(
    parameter int PIPE_LAT = 3,
    parameter int RK_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      klen,
    input  logic            dec,
    input  logic            abort,
    output logic            ready,
    output logic            busy,
    output logic            sel,
    output logic            rk_en,
    output logic [RK_W-1:0] rk_idx,
    output logic            wk_en,
    output logic            wk_final,
    output logic [RK_W-1:0] round,
    output logic            done,
    output logic            err
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
    localparam logic [2:0] CYC_LAST = 3'(PIPE_LAT - 1);
    state_t          state;
    logic [2:0]      cyc;
    logic [RK_W-1:0] nr;
    logic            dec_q;
    logic [RK_W-1:0] nr_in;
    logic [RK_W-1:0] last_round;
    logic [RK_W-1:0] next_round;
    // round count for the requested key length and helpers for the next round index
    always_comb begin
        nr_in      = klen == 2'b00 ? RK_W'(18) : klen == 2'b01 ? RK_W'(22) : RK_W'(26);
        last_round = nr - RK_W'(1);
        next_round = round + RK_W'(1);
    end
    // sequencer: all outputs registered alongside the state so no input reaches an output combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            sel      <= 1'b0;
            rk_en    <= 1'b0;
            rk_idx   <= '0;
            wk_en    <= 1'b0;
            wk_final <= 1'b0;
            round    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cyc      <= '0;
            nr       <= '0;
            dec_q    <= 1'b0;
        end else if (abort && state != IDLE) begin
            state    <= IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            sel      <= 1'b0;
            rk_en    <= 1'b0;
            wk_en    <= 1'b0;
            wk_final <= 1'b0;
            round    <= '0;
            done     <= 1'b0;
            cyc      <= '0;
        end else begin
            rk_en    <= 1'b0;
            wk_en    <= 1'b0;
            wk_final <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && klen == 2'b11) begin
                        err <= 1'b1;
                    end else if (start) begin
                        state <= LOAD;
                        nr    <= nr_in;
                        dec_q <= dec;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        wk_en <= 1'b1;
                        sel   <= 1'b0;
                        round <= '0;
                        cyc   <= '0;
                    end
                end
                LOAD: begin
                    state  <= ROUND;
                    rk_en  <= 1'b1;
                    rk_idx <= dec_q ? last_round : '0;
                    sel    <= 1'b0;
                    cyc    <= '0;
                end
                ROUND: begin
                    if (cyc != CYC_LAST) begin
                        cyc <= cyc + 3'd1;
                    end else if (round == last_round) begin
                        state    <= FINAL;
                        wk_en    <= 1'b1;
                        wk_final <= 1'b1;
                        sel      <= 1'b1;
                        cyc      <= '0;
                    end else begin
                        round  <= next_round;
                        cyc    <= '0;
                        rk_en  <= 1'b1;
                        rk_idx <= dec_q ? last_round - next_round : next_round;
                        sel    <= 1'b1;
                    end
                end
                FINAL: begin
                    state <= DONE;
                    done  <= 1'b1;
                    sel   <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    round <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clefia_round_ctrl.sv
// tb_clefia_round_ctrl: scoreboard bench for the CLEFIA round sequencer
module tb_clefia_round_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, dec = 1'b0, abort = 1'b0;
    logic [1:0] klen = 2'b00;
    logic ready, busy, sel, rk_en, wk_en, wk_final, done, err;
    logic [4:0] rk_idx, round;
    logic start1 = 1'b0, dec1 = 1'b0;
    logic [1:0] klen1 = 2'b00;
    logic ready1, busy1, sel1, rk_en1, wk_en1, wk_final1, done1, err1;
    logic [4:0] rk_idx1, round1;

    typedef struct {
        int cyc;
        int kind;
        int idx;
        int fl;
    } ev_t;
    ev_t q0[$];
    ev_t q1[$];
    int edges = 0;
    int checks = 0;
    int failures = 0;

    clefia_round_ctrl #(.PIPE_LAT(3), .RK_W(5)) u3 (
        .clk(clk), .rst(rst), .start(start), .klen(klen), .dec(dec), .abort(abort),
        .ready(ready), .busy(busy), .sel(sel), .rk_en(rk_en), .rk_idx(rk_idx),
        .wk_en(wk_en), .wk_final(wk_final), .round(round), .done(done), .err(err)
    );

    clefia_round_ctrl #(.PIPE_LAT(1), .RK_W(5)) u1 (
        .clk(clk), .rst(rst), .start(start1), .klen(klen1), .dec(dec1), .abort(1'b0),
        .ready(ready1), .busy(busy1), .sel(sel1), .rk_en(rk_en1), .rk_idx(rk_idx1),
        .wk_en(wk_en1), .wk_final(wk_final1), .round(round1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d at cycle %0d", nm, act, exp, edges);
        end
    endtask

    task automatic push(input int w, input int c, input int k, input int i, input int f);
        ev_t e;
        e.cyc = c;
        e.kind = k;
        e.idx = i;
        e.fl = f;
        if (w == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // kinds: 0=wk (fl = wk_final + 2*sel), 1=rk (fl = sel), 2=done, 3=err
    task automatic expect_op(input int w, input int b, input int nr, input int d, input int p);
        push(w, b + 1, 0, 0, 0);
        for (int r = 0; r < nr; r++) push(w, b + 2 + r * p, 1, d != 0 ? nr - 1 - r : r, r > 0 ? 1 : 0);
        push(w, b + 2 + nr * p, 0, 0, 3);
        push(w, b + 3 + nr * p, 2, 0, 0);
    endtask

    task automatic observe(input string nm, input int w, input int k, input int i, input int f);
        ev_t e;
        checks++;
        if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL %s unexpected event: got kind=%0d idx=%0d fl=%0d at cycle %0d, required none", nm, k, i, f, edges);
        end else begin
            if (w == 0) e = q0.pop_front();
            else e = q1.pop_front();
            if (e.cyc != edges || e.kind != k || e.idx != i || e.fl != f) begin
                failures++;
                $display("FAIL %s event: got cyc=%0d kind=%0d idx=%0d fl=%0d required cyc=%0d kind=%0d idx=%0d fl=%0d",
                         nm, edges, k, i, f, e.cyc, e.kind, e.idx, e.fl);
            end
        end
    endtask

    always @(negedge clk)
        if (rk_en || wk_en || done || err)
            observe("u3", 0, rk_en ? 1 : wk_en ? 0 : done ? 2 : 3, rk_en ? int'(rk_idx) : 0,
                    rk_en ? int'(sel) : wk_en ? int'(wk_final) + 2 * int'(sel) : 0);

    always @(negedge clk)
        if (rk_en1 || wk_en1 || done1 || err1)
            observe("u1", 1, rk_en1 ? 1 : wk_en1 ? 0 : done1 ? 2 : 3, rk_en1 ? int'(rk_idx1) : 0,
                    rk_en1 ? int'(sel1) : wk_en1 ? int'(wk_final1) + 2 * int'(sel1) : 0);

    task automatic arm(input int w, input logic [1:0] k, input logic d, input logic a, output int b);
        @(negedge clk);
        b = edges;
        if (w == 0) begin
            start = 1'b1;
            klen = k;
            dec = d;
            abort = a;
        end else begin
            start1 = 1'b1;
            klen1 = k;
            dec1 = d;
        end
    endtask

    task automatic drop();
        @(negedge clk);
        start = 1'b0;
        start1 = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (edges < c) @(negedge clk);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ready"}, int'(ready), 1);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_sel"}, int'(sel), 0);
        chk({nm, "_rk_en"}, int'(rk_en), 0);
        chk({nm, "_wk_en"}, int'(wk_en), 0);
        chk({nm, "_wk_final"}, int'(wk_final), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_err"}, int'(err), 0);
        chk({nm, "_round"}, int'(round), 0);
    endtask

    initial begin
        int b;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_rk_idx", int'(rk_idx), 0);
        chk("reset_ready1", int'(ready1), 1);
        rst = 1'b0;
        // encrypt 128
        arm(0, 2'b00, 1'b0, 1'b0, b);
        expect_op(0, b, 18, 0, 3);
        drop();
        chk("enc128_busy_load", int'(busy), 1);
        wait_until(b + 4);
        chk("enc128_sel_r0", int'(sel), 0);
        wait_until(b + 6);
        chk("enc128_sel_r1", int'(sel), 1);
        chk("enc128_round_r1", int'(round), 1);
        wait_until(b + 57);
        chk("enc128_busy_done", int'(busy), 1);
        wait_until(b + 58);
        chk_idle("enc128_end");
        // decrypt 256 with abort alongside start in IDLE
        arm(0, 2'b10, 1'b1, 1'b1, b);
        expect_op(0, b, 26, 1, 3);
        drop();
        wait_until(b + 82);
        chk("dec256_ready", int'(ready), 1);
        // illegal key length
        arm(0, 2'b11, 1'b0, 1'b0, b);
        push(0, b + 1, 3, 0, 0);
        drop();
        chk("illegal_ready", int'(ready), 1);
        chk("illegal_busy", int'(busy), 0);
        wait_until(b + 4);
        // start during round 4 is ignored
        arm(0, 2'b00, 1'b0, 1'b0, b);
        expect_op(0, b, 18, 0, 3);
        drop();
        wait_until(b + 14);
        start = 1'b1;
        klen = 2'b10;
        dec = 1'b1;
        wait_until(b + 17);
        start = 1'b0;
        klen = 2'b00;
        dec = 1'b0;
        wait_until(b + 58);
        chk("busy_start_ready", int'(ready), 1);
        // abort during round 7
        arm(0, 2'b00, 1'b0, 1'b0, b);
        push(0, b + 1, 0, 0, 0);
        for (int r = 0; r < 8; r++) push(0, b + 2 + 3 * r, 1, r, r > 0 ? 1 : 0);
        drop();
        wait_until(b + 24);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        wait_until(b + 30);
        arm(0, 2'b00, 1'b0, 1'b0, b);
        expect_op(0, b, 18, 0, 3);
        drop();
        wait_until(b + 58);
        chk("post_abort_ready", int'(ready), 1);
        // reset during FINAL of a 192-bit encrypt
        arm(0, 2'b01, 1'b0, 1'b0, b);
        push(0, b + 1, 0, 0, 0);
        for (int r = 0; r < 22; r++) push(0, b + 2 + 3 * r, 1, r, r > 0 ? 1 : 0);
        push(0, b + 68, 0, 0, 3);
        drop();
        wait_until(b + 68);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_final");
        chk("rst_final_rk_idx", int'(rk_idx), 0);
        wait_until(b + 75);
        // back-to-back: decrypt then encrypt with start held
        arm(0, 2'b00, 1'b1, 1'b0, b);
        expect_op(0, b, 18, 1, 3);
        expect_op(0, b + 58, 18, 0, 3);
        wait_until(b + 58);
        chk("b2b_ready", int'(ready), 1);
        dec = 1'b0;
        drop();
        chk("b2b_busy", int'(busy), 1);
        wait_until(b + 117);
        chk("b2b_ready2", int'(ready), 1);
        // PIPE_LAT=1, 192-bit encrypt
        arm(1, 2'b01, 1'b0, 1'b0, b);
        expect_op(1, b, 22, 0, 1);
        drop();
        wait_until(b + 26);
        chk("p1_ready", int'(ready1), 1);
        wait_until(b + 28);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
